ifu_inst_fetch: RTL and testbench

Instruction-fetch requester that consumes the PC counter's (IFU_o_pc, pc_change) pair. Each pc_change pulse issues one AXI4-Lite read of the instruction word at that PC. The returned word goes to the IF/ID boundary through a valid/ready handshake. The block raises a busy/stall request toward the forwarding unit while a fetch is outstanding, and discards responses on a branch redirect.

---
 rtl/ifu_inst_fetch_pkg.sv | 22 ++
 rtl/ifu_inst_fetch_timeout.sv | 30 +++
 rtl/ifu_inst_fetch.sv | 189 ++++++++++++++++++
 tb/tb_ifu_inst_fetch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_inst_fetch_pkg.sv
// Shared constants for the instruction-fetch unit: FSM encodings, AXI response
// codes and reset/default values.
package ifu_pkg_ysyx23060136;

    // Fetch FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // AXI read response codes
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // addi x0, x0, 0
    localparam logic [31:0] IFU_INST_NOP = 32'h00000013;

    localparam logic [31:0] PC_RESET = 32'h00000000;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/ifu_inst_fetch_timeout.sv
// 8-bit saturating cycle counter for the fetch data phase. o_expired is raised
// during the TIMEOUT-th enabled cycle after a clear.
module ifu_fetch_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Count enabled cycles, saturating at 8'hFF
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_en && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expired = i_en & (r_cnt >= LIMIT);

endmodule

// File: rtl/ifu_inst_fetch.sv
// Instruction fetch requester: turns each pc_change pulse into one AXI4-Lite
// read and hands the returned word to IF/ID through a valid/ready handshake.
// One pending PC slot buffers a redirect that arrives while a fetch is busy.
module ifu_inst_fetch
    import ifu_pkg_ysyx23060136::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] INST_NOP = DATA_W'(IFU_INST_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] IFU_i_pc,
    input  logic              pc_change,
    input  logic              BRANCH_flush,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [DATA_W-1:0] IFU_o_inst,
    output logic [ADDR_W-1:0] IFU_o_pc,
    output logic              IFU_o_valid,
    input  logic              IFU_i_ready,
    output logic              IFU_o_busy,
    output logic              IFU_o_fault
);

    logic [1:0]        r_state,   w_state_d;
    logic [ADDR_W-1:0] r_araddr,  w_araddr_d;
    logic [ADDR_W-1:0] r_opc,     w_opc_d;
    logic [DATA_W-1:0] r_inst,    w_inst_d;
    logic              r_pend,    w_pend_d;
    logic [ADDR_W-1:0] r_pend_pc, w_pend_pc_d;
    // r_drop: the in-flight beat belongs to a flushed fetch and ends it.
    // r_stale: a timed-out fetch may still return one beat; swallow it silently.
    logic              r_drop,    w_drop_d;
    logic              r_stale,   w_stale_d;
    logic              r_fault,   w_fault_d;

    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_stale_beat;
    logic              w_data_beat;
    logic              w_drop_eff;
    logic              w_pend_v;
    logic [ADDR_W-1:0] w_pend_pc;
    logic              w_expired;

    assign w_ar_hs      = (r_state == ST_ADDR) & ARREADY;
    assign w_r_hs       = RVALID & RREADY;
    assign w_stale_beat = w_r_hs & r_stale;
    assign w_data_beat  = w_r_hs & ~r_stale & (r_state == ST_DATA);
    assign w_drop_eff   = r_drop | BRANCH_flush;
    // Pending view after this cycle's flush (first) and pc_change (second)
    assign w_pend_v     = pc_change | (r_pend & ~BRANCH_flush);
    assign w_pend_pc    = pc_change ? IFU_i_pc : r_pend_pc;

    ifu_fetch_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_ar_hs),
        .i_en      (r_state == ST_DATA),
        .o_expired (w_expired)
    );

    // Next-state logic for the fetch FSM and its datapath registers
    always_comb begin
        w_state_d   = r_state;
        w_araddr_d  = r_araddr;
        w_opc_d     = r_opc;
        w_inst_d    = r_inst;
        w_pend_d    = w_pend_v;
        w_pend_pc_d = w_pend_pc;
        w_drop_d    = r_drop;
        w_stale_d   = r_stale & ~w_stale_beat;
        w_fault_d   = r_fault;

        case (r_state)
            ST_IDLE: begin
                if (w_pend_v) begin
                    w_state_d  = ST_ADDR;
                    w_araddr_d = w_pend_pc;
                    w_pend_d   = FALSE;
                end
            end
            ST_ADDR: begin
                // The request cannot be withdrawn; a flush only marks its beat.
                if (BRANCH_flush) w_drop_d = TRUE;
                if (ARREADY) w_state_d = ST_DATA;
            end
            ST_DATA: begin
                if (w_data_beat) begin
                    if (w_drop_eff) begin
                        w_drop_d = FALSE;
                        if (w_pend_v) begin
                            w_state_d  = ST_ADDR;
                            w_araddr_d = w_pend_pc;
                            w_pend_d   = FALSE;
                        end else begin
                            w_state_d = ST_IDLE;
                        end
                    end else begin
                        w_state_d = ST_HOLD;
                        w_opc_d   = r_araddr;
                        if (RRESP != RESP_OKAY) begin
                            w_fault_d = TRUE;
                            w_inst_d  = INST_NOP;
                        end else begin
                            w_inst_d  = RDATA;
                        end
                    end
                end else if (w_expired) begin
                    w_fault_d = TRUE;
                    w_stale_d = TRUE;
                    w_drop_d  = FALSE;
                    if (w_drop_eff) begin
                        if (w_pend_v) begin
                            w_state_d  = ST_ADDR;
                            w_araddr_d = w_pend_pc;
                            w_pend_d   = FALSE;
                        end else begin
                            w_state_d = ST_IDLE;
                        end
                    end else begin
                        w_state_d = ST_HOLD;
                        w_opc_d   = r_araddr;
                        w_inst_d  = INST_NOP;
                    end
                end else if (BRANCH_flush) begin
                    w_drop_d = TRUE;
                end
            end
            default: begin // ST_HOLD
                // Flush and accept both release the slot; pending (if any) goes next.
                if (BRANCH_flush || IFU_i_ready) begin
                    if (w_pend_v) begin
                        w_state_d  = ST_ADDR;
                        w_araddr_d = w_pend_pc;
                        w_pend_d   = FALSE;
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_araddr  <= ADDR_W'(PC_RESET);
            r_opc     <= ADDR_W'(PC_RESET);
            r_inst    <= INST_NOP;
            r_pend    <= FALSE;
            r_pend_pc <= ADDR_W'(PC_RESET);
            r_drop    <= FALSE;
            r_stale   <= FALSE;
            r_fault   <= FALSE;
        end else begin
            r_state   <= w_state_d;
            r_araddr  <= w_araddr_d;
            r_opc     <= w_opc_d;
            r_inst    <= w_inst_d;
            r_pend    <= w_pend_d;
            r_pend_pc <= w_pend_pc_d;
            r_drop    <= w_drop_d;
            r_stale   <= w_stale_d;
            r_fault   <= w_fault_d;
        end
    end

    assign ARADDR      = r_araddr;
    assign ARVALID     = (r_state == ST_ADDR);
    assign RREADY      = (r_state == ST_DATA) | r_stale;
    assign IFU_o_valid = (r_state == ST_HOLD);
    assign IFU_o_inst  = IFU_o_valid ? r_inst : INST_NOP;
    assign IFU_o_pc    = r_opc;
    assign IFU_o_fault = r_fault;
    assign IFU_o_busy  = (r_state != ST_IDLE) &
                         ~((r_state == ST_HOLD) & IFU_i_ready & ~r_pend);

endmodule

// File: tb/tb_ifu_inst_fetch.sv
// Directed bench for ifu_inst_fetch. Stimulus pushes expected AR addresses and
// delivered (inst, pc) pairs into queues; a negedge monitor pops and compares
// on every AR handshake and every IF/ID accept.
module tb_ifu_inst_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IFU_i_pc;
    logic        pc_change;
    logic        BRANCH_flush;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] IFU_o_inst;
    logic [31:0] IFU_o_pc;
    logic        IFU_o_valid;
    logic        IFU_i_ready;
    logic        IFU_o_busy;
    logic        IFU_o_fault;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_ar[$];
    logic [63:0] q_out[$];
    logic [31:0] mon_ar;
    logic [63:0] mon_out;

    always #5 clk = ~clk;

    ifu_inst_fetch #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (8),
        .INST_NOP (NOP)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .IFU_i_pc     (IFU_i_pc),
        .pc_change    (pc_change),
        .BRANCH_flush (BRANCH_flush),
        .ARADDR       (ARADDR),
        .ARVALID      (ARVALID),
        .ARREADY      (ARREADY),
        .RDATA        (RDATA),
        .RRESP        (RRESP),
        .RVALID       (RVALID),
        .RREADY       (RREADY),
        .IFU_o_inst   (IFU_o_inst),
        .IFU_o_pc     (IFU_o_pc),
        .IFU_o_valid  (IFU_o_valid),
        .IFU_i_ready  (IFU_i_ready),
        .IFU_o_busy   (IFU_o_busy),
        .IFU_o_fault  (IFU_o_fault)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_arvalid"}, ARVALID, 0);
        chk({tag, "_rready"}, RREADY, 0);
        chk({tag, "_valid"}, IFU_o_valid, 0);
        chk({tag, "_busy"}, IFU_o_busy, 0);
        chk({tag, "_fault"}, IFU_o_fault, 0);
        chk({tag, "_araddr"}, ARADDR, 0);
        chk({tag, "_pc"}, IFU_o_pc, 0);
        chk({tag, "_inst"}, IFU_o_inst, NOP);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            if (ARVALID && ARREADY) begin
                if (q_ar.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ar_unexpected: got addr %h expected none", ARADDR);
                end else begin
                    mon_ar = q_ar.pop_front();
                    chk("ar_addr", ARADDR, mon_ar);
                end
            end
            if (IFU_o_valid && IFU_i_ready) begin
                if (q_out.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got inst %h pc %h expected none",
                             IFU_o_inst, IFU_o_pc);
                end else begin
                    mon_out = q_out.pop_front();
                    chk("out_inst", IFU_o_inst, mon_out[63:32]);
                    chk("out_pc", IFU_o_pc, mon_out[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; pc_change = 1'b0; IFU_i_pc = '0; BRANCH_flush = 1'b0;
        ARREADY = 1'b0; RDATA = '0; RRESP = 2'b00; RVALID = 1'b0; IFU_i_ready = 1'b1;
        #12;
        check_reset("rst0");
        step();
        rst = 1'b1;
        step();

        // Basic fetch, minimum latency
        IFU_i_pc = 32'h80000000; pc_change = 1'b1; ARREADY = 1'b1;
        q_ar.push_back(32'h80000000); q_out.push_back({32'h00100093, 32'h80000000});
        chk("t1_idle_busy", IFU_o_busy, 0);
        step(); pc_change = 1'b0;
        chk("t1_arvalid", ARVALID, 1);
        chk("t1_araddr", ARADDR, 32'h80000000);
        step();
        chk("t1_rready", RREADY, 1);
        chk("t1_novalid", IFU_o_valid, 0);
        RVALID = 1'b1; RDATA = 32'h00100093; RRESP = 2'b00;
        step(); RVALID = 1'b0;
        chk("t1_valid", IFU_o_valid, 1);
        chk("t1_inst", IFU_o_inst, 32'h00100093);
        chk("t1_pc", IFU_o_pc, 32'h80000000);
        chk("t1_busy_accept", IFU_o_busy, 0);
        step();
        chk("t1_valid_off", IFU_o_valid, 0);
        chk("t1_inst_nop", IFU_o_inst, NOP);
        chk("t1_busy_idle", IFU_o_busy, 0);

        // Backpressure on AR and on IF/ID
        ARREADY = 1'b0; IFU_i_ready = 1'b0;
        IFU_i_pc = 32'h80000010; pc_change = 1'b1;
        q_ar.push_back(32'h80000010); q_out.push_back({32'h00200113, 32'h80000010});
        step(); pc_change = 1'b0; IFU_i_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_arvalid", ARVALID, 1);
            chk("t2_araddr", ARADDR, 32'h80000010);
            chk("t2_busy_addr", IFU_o_busy, 1);
            step();
        end
        chk("t2_arvalid5", ARVALID, 1);
        chk("t2_araddr5", ARADDR, 32'h80000010);
        ARREADY = 1'b1;
        step(); ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'h00200113;
        step(); RVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_valid", IFU_o_valid, 1);
            chk("t2_hold_inst", IFU_o_inst, 32'h00200113);
            chk("t2_hold_pc", IFU_o_pc, 32'h80000010);
            chk("t2_hold_busy", IFU_o_busy, 1);
            step();
        end
        IFU_i_ready = 1'b1; #1;
        chk("t2_busy_accept", IFU_o_busy, 0);
        step();
        chk("t2_valid_off", IFU_o_valid, 0);

        // Pending slot: newest PC wins, exactly two AR transactions
        IFU_i_ready = 1'b0; ARREADY = 1'b1;
        IFU_i_pc = 32'h80000000; pc_change = 1'b1;
        q_ar.push_back(32'h80000000); q_ar.push_back(32'h80000008);
        q_out.push_back({32'h00300193, 32'h80000000});
        q_out.push_back({32'h00400213, 32'h80000008});
        step(); pc_change = 1'b0;
        step();
        IFU_i_pc = 32'h80000004; pc_change = 1'b1;
        step();
        IFU_i_pc = 32'h80000008;
        step();
        pc_change = 1'b0; RVALID = 1'b1; RDATA = 32'h00300193;
        step(); RVALID = 1'b0;
        chk("t3_valid1", IFU_o_valid, 1);
        chk("t3_pc1", IFU_o_pc, 32'h80000000);
        chk("t3_busy_hold", IFU_o_busy, 1);
        chk("t3_no_ar_hold", ARVALID, 0);
        IFU_i_ready = 1'b1; #1;
        chk("t3_busy_pending", IFU_o_busy, 1);
        step();
        chk("t3_arvalid2", ARVALID, 1);
        chk("t3_araddr2", ARADDR, 32'h80000008);
        chk("t3_valid_gap", IFU_o_valid, 0);
        step();
        RVALID = 1'b1; RDATA = 32'h00400213;
        step(); RVALID = 1'b0;
        chk("t3_valid2", IFU_o_valid, 1);
        chk("t3_inst2", IFU_o_inst, 32'h00400213);
        chk("t3_pc2", IFU_o_pc, 32'h80000008);
        step();
        chk("t3_idle_ar", ARVALID, 0);
        chk("t3_q_ar", q_ar.size(), 0);
        chk("t3_q_out", q_out.size(), 0);

        // Flush in DATA with a simultaneous redirect
        IFU_i_pc = 32'h80000040; pc_change = 1'b1;
        q_ar.push_back(32'h80000040); q_ar.push_back(32'h80000100);
        q_out.push_back({32'h00500293, 32'h80000100});
        step(); pc_change = 1'b0;
        step();
        BRANCH_flush = 1'b1; pc_change = 1'b1; IFU_i_pc = 32'h80000100;
        step();
        BRANCH_flush = 1'b0; pc_change = 1'b0;
        chk("t4_rready", RREADY, 1);
        RVALID = 1'b1; RDATA = 32'hbad0bad0;
        step(); RVALID = 1'b0;
        chk("t4_dropped", IFU_o_valid, 0);
        chk("t4_arvalid", ARVALID, 1);
        chk("t4_araddr", ARADDR, 32'h80000100);
        step();
        RVALID = 1'b1; RDATA = 32'h00500293;
        step(); RVALID = 1'b0;
        chk("t4_valid", IFU_o_valid, 1);
        chk("t4_inst", IFU_o_inst, 32'h00500293);
        chk("t4_pc", IFU_o_pc, 32'h80000100);
        step();
        chk("t4_valid_off", IFU_o_valid, 0);

        // Error response
        IFU_i_pc = 32'h80000200; pc_change = 1'b1;
        q_ar.push_back(32'h80000200); q_out.push_back({NOP, 32'h80000200});
        step(); pc_change = 1'b0;
        step();
        chk("t5_fault_before", IFU_o_fault, 0);
        RVALID = 1'b1; RRESP = 2'b10; RDATA = 32'hffffffff;
        step(); RVALID = 1'b0; RRESP = 2'b00;
        chk("t5_valid", IFU_o_valid, 1);
        chk("t5_fault", IFU_o_fault, 1);
        chk("t5_inst_nop", IFU_o_inst, NOP);
        chk("t5_pc", IFU_o_pc, 32'h80000200);
        step();
        chk("t5_fault_sticky", IFU_o_fault, 1);
        chk("t5_valid_off", IFU_o_valid, 0);

        // Asynchronous reset in DATA, off the clock edge
        IFU_i_pc = 32'h80000300; pc_change = 1'b1;
        q_ar.push_back(32'h80000300);
        step(); pc_change = 1'b0;
        step();
        chk("t6_rready", RREADY, 1);
        chk("t6_busy", IFU_o_busy, 1);
        #3;
        rst = 1'b0;
        #1;
        check_reset("t6_async");
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t6_no_ar", ARVALID, 0);
            step();
        end

        // Timeout after 8 DATA cycles, late beat swallowed
        IFU_i_ready = 1'b0;
        IFU_i_pc = 32'h80000400; pc_change = 1'b1;
        q_ar.push_back(32'h80000400); q_out.push_back({NOP, 32'h80000400});
        step(); pc_change = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            chk("t7_fault_wait", IFU_o_fault, 0);
            chk("t7_rready_wait", RREADY, 1);
            chk("t7_valid_wait", IFU_o_valid, 0);
            step();
        end
        chk("t7_fault", IFU_o_fault, 1);
        chk("t7_valid", IFU_o_valid, 1);
        chk("t7_inst_nop", IFU_o_inst, NOP);
        chk("t7_pc", IFU_o_pc, 32'h80000400);
        chk("t7_rready_late", RREADY, 1);
        RVALID = 1'b1; RDATA = 32'h12345678;
        step(); RVALID = 1'b0;
        chk("t7_valid_after_late", IFU_o_valid, 1);
        chk("t7_inst_after_late", IFU_o_inst, NOP);
        chk("t7_rready_done", RREADY, 0);
        IFU_i_ready = 1'b1;
        step();
        chk("t7_valid_off", IFU_o_valid, 0);
        chk("t7_fault_sticky", IFU_o_fault, 1);
        chk("t7_idle_ar", ARVALID, 0);
        chk("t7_idle_busy", IFU_o_busy, 0);

        chk("end_q_ar", q_ar.size(), 0);
        chk("end_q_out", q_out.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
